// File: rtl/umi_queue_arbiter_if.sv
// UMI request/transmit bundle shared by the requesters, the queue arbiter and the sink.
// Handshake: a beat moves on a rising edge where valid && ready; valid never waits on ready.
interface umi_queue_arbiter_if #(
  parameter int N  = 2,
  parameter int DW = 256,
  parameter int AW = 64,
  parameter int CW = 32
);
  localparam int SW = $clog2(N);

  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic [N*AW-1:0] in_srcaddr;
  logic [N*AW-1:0] in_dstaddr;
  logic [N*CW-1:0] in_cmd;

  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [AW-1:0]   out_srcaddr;
  logic [AW-1:0]   out_dstaddr;
  logic [CW-1:0]   out_cmd;
  logic [SW-1:0]   out_src;

  modport slave (
    input  in_valid, in_data, in_srcaddr, in_dstaddr, in_cmd, out_ready,
    output in_ready, out_valid, out_data, out_srcaddr, out_dstaddr, out_cmd, out_src
  );

  modport master (
    output in_valid, in_data, in_srcaddr, in_dstaddr, in_cmd, out_ready,
    input  in_ready, out_valid, out_data, out_srcaddr, out_dstaddr, out_cmd, out_src
  );
endinterface

// File: rtl/umi_queue_arbiter.sv
// Round-robin N:1 UMI arbiter that keeps multi-beat packets atomic (lock until cmd[22] EOM).
// Optional stall watchdog: define UMI_QUEUE_ARB_WATCHDOG_EN.
module umi_queue_arbiter #(
  parameter int N       = 2,
  parameter int DW      = 256,
  parameter int AW      = 64,
  parameter int CW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  umi_queue_arbiter_if.slave    bus,
  output logic                  stall_err,
  output logic [0:0]            dbg_state_o
);
  localparam int SW = $clog2(N);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [AW-1:0] out_srcaddr_q, out_dstaddr_q;
  logic [CW-1:0] out_cmd_q;
  logic [SW-1:0] out_src_q;

  logic [SW-1:0] cand;
  logic          cand_vld;
  logic          space;
  logic          accept;
  logic          eom;

  // Descending scan so the last hit is the first valid requester after rr_ptr.
  always_comb begin
    cand     = owner_q;
    cand_vld = 1'b0;
    if (state_q == LOCKED) begin
      cand_vld = bus.in_valid[owner_q];
    end else begin
      for (int k = N; k >= 1; k--) begin
        if (bus.in_valid[(int'(rr_ptr_q) + k) % N]) begin
          cand     = SW'((int'(rr_ptr_q) + k) % N);
          cand_vld = 1'b1;
        end
      end
    end
  end

  assign space  = !out_valid_q || bus.out_ready;
  assign accept = !rst && space && cand_vld;
  assign eom    = bus.in_cmd[int'(cand) * CW + 22];

  always_comb begin
    bus.in_ready = '0;
    if (accept) bus.in_ready[cand] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (eom) begin
        state_d  = IDLE;
        rr_ptr_d = cand;
      end else begin
        state_d = LOCKED;
        owner_d = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= SW'(N - 1);
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_srcaddr_q <= '0;
      out_dstaddr_q <= '0;
      out_cmd_q     <= '0;
      out_src_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        out_valid_q   <= 1'b1;
        out_data_q    <= bus.in_data[int'(cand) * DW +: DW];
        out_srcaddr_q <= bus.in_srcaddr[int'(cand) * AW +: AW];
        out_dstaddr_q <= bus.in_dstaddr[int'(cand) * AW +: AW];
        out_cmd_q     <= bus.in_cmd[int'(cand) * CW +: CW];
        out_src_q     <= cand;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_srcaddr = out_srcaddr_q;
  assign bus.out_dstaddr = out_dstaddr_q;
  assign bus.out_cmd     = out_cmd_q;
  assign bus.out_src     = out_src_q;
  assign dbg_state_o     = state_q;

`ifdef UMI_QUEUE_ARB_WATCHDOG_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0] wd_cnt_q, wd_cnt_d;
  logic            stall_q;

  // Counts only while the owner is silent; backpressure with valid held does not count.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (accept || state_q != LOCKED) begin
      wd_cnt_d = '0;
    end else if (!bus.in_valid[owner_q] && wd_cnt_q != CNTW'(TIMEOUT)) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      stall_q  <= stall_q | (wd_cnt_d == CNTW'(TIMEOUT));
    end
  end

  assign stall_err = stall_q;
`else
  assign stall_err = 1'b0;
`endif
endmodule
